// File: rtl/noc_input_vc_buffer.sv
// Router input stage: per-VC first-word-fall-through FIFOs with upstream space
// reporting, per-VC packet framing checks and sticky protocol/overflow errors.
module noc_input_vc_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 4,
  parameter int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                    noc_clk,
  input  logic                                    noc_rst_n,
  input  logic                                    in_valid,
  input  logic [VC_W-1:0]                         in_vc,
  input  logic [DATA_WIDTH-1:0]                   in_flit,
  input  logic                                    in_head,
  input  logic                                    in_tail,
  output logic [CHANNELS-1:0]                     in_vc_ready,
  output logic [CHANNELS-1:0]                     out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]          out_flit,
  output logic [CHANNELS-1:0]                     out_head,
  output logic [CHANNELS-1:0]                     out_tail,
  input  logic [CHANNELS-1:0]                     out_ready,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]   occupancy,
  output logic                                    protocol_err,
  output logic                                    overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [VC_W:0]   CH_LIMIT = (VC_W + 1)'(CHANNELS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } vc_state_e;

  // Entry layout: {head, tail, flit}
  logic [EW-1:0]         mem_q   [CHANNELS][DEPTH];
  logic [EW-1:0]         mem_d   [CHANNELS][DEPTH];
  logic [PW-1:0]         wr_ptr_q [CHANNELS];
  logic [PW-1:0]         wr_ptr_d [CHANNELS];
  logic [PW-1:0]         rd_ptr_q [CHANNELS];
  logic [PW-1:0]         rd_ptr_d [CHANNELS];
  logic [CW-1:0]         count_q  [CHANNELS];
  logic [CW-1:0]         count_d  [CHANNELS];
  vc_state_e             state_q  [CHANNELS];
  vc_state_e             state_d  [CHANNELS];
  logic                  protocol_err_q, protocol_err_d;
  logic                  overflow_err_q, overflow_err_d;
  logic [CHANNELS-1:0]   in_vc_ready_q, in_vc_ready_d;
  logic [CHANNELS-1:0]   out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]   out_head_q, out_head_d;
  logic [CHANNELS-1:0]   out_tail_q, out_tail_d;
  logic [CHANNELS*DATA_WIDTH-1:0] out_flit_q, out_flit_d;

  logic                  vc_legal_s;
  logic [CHANNELS-1:0]   push_s;
  logic [CHANNELS-1:0]   pop_s;
  logic [EW-1:0]         head_entry_s [CHANNELS];

  // Next-state: push/pop decode, FIFO pointers, framing FSMs, errors and the
  // registered view of each FIFO head after this edge.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    protocol_err_d = protocol_err_q;
    overflow_err_d = overflow_err_q;
    in_vc_ready_d  = {CHANNELS{1'b0}};
    out_valid_d    = {CHANNELS{1'b0}};
    out_head_d     = {CHANNELS{1'b0}};
    out_tail_d     = {CHANNELS{1'b0}};
    out_flit_d     = {(CHANNELS*DATA_WIDTH){1'b0}};
    push_s         = {CHANNELS{1'b0}};
    pop_s          = {CHANNELS{1'b0}};
    vc_legal_s     = ({1'b0, in_vc} < CH_LIMIT);

    for (int c = 0; c < CHANNELS; c++) begin
      head_entry_s[c] = {EW{1'b0}};
      // Space is judged on the registered count only, so a pop never frees room
      // for a push in the same cycle.
      push_s[c] = in_valid && vc_legal_s && (in_vc == VC_W'(c)) &&
                  (count_q[c] != FULL_CNT);
      pop_s[c]  = (count_q[c] != {CW{1'b0}}) && out_ready[c];

      case ({push_s[c], pop_s[c]})
        2'b10:   count_d[c] = count_q[c] + CW'(1);
        2'b01:   count_d[c] = count_q[c] - CW'(1);
        default: count_d[c] = count_q[c];
      endcase

      if (pop_s[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
      end else begin
        rd_ptr_d[c] = rd_ptr_q[c];
      end

      if (push_s[c]) begin
        mem_d[c][wr_ptr_q[c]] = {in_head, in_tail, in_flit};
        wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
        case (state_q[c])
          ST_IDLE: begin
            if (in_head) begin
              state_d[c] = in_tail ? ST_IDLE : ST_BODY;
            end else begin
              protocol_err_d = 1'b1;
              state_d[c]     = ST_IDLE;
            end
          end
          ST_BODY: begin
            // A head mid-packet is flagged, then treated as a fresh packet start.
            if (in_head) begin
              protocol_err_d = 1'b1;
            end else begin
              protocol_err_d = protocol_err_d;
            end
            state_d[c] = in_tail ? ST_IDLE : ST_BODY;
          end
          default: state_d[c] = ST_IDLE;
        endcase
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c];
      end
    end

    if (in_valid && (push_s == {CHANNELS{1'b0}})) begin
      overflow_err_d = 1'b1;
    end else begin
      overflow_err_d = overflow_err_d;
    end

    for (int c = 0; c < CHANNELS; c++) begin
      in_vc_ready_d[c] = (count_d[c] != FULL_CNT);
      out_valid_d[c]   = (count_d[c] != {CW{1'b0}});
      if (out_valid_d[c]) begin
        head_entry_s[c] = mem_d[c][rd_ptr_d[c]];
      end else begin
        head_entry_s[c] = {EW{1'b0}};
      end
      out_head_d[c] = head_entry_s[c][DATA_WIDTH+1];
      out_tail_d[c] = head_entry_s[c][DATA_WIDTH];
      out_flit_d[c*DATA_WIDTH +: DATA_WIDTH] = head_entry_s[c][DATA_WIDTH-1:0];
    end
  end

  // State register; reset clears storage so nothing from a prior packet survives.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[c][d] <= {EW{1'b0}};
        end
        wr_ptr_q[c] <= {PW{1'b0}};
        rd_ptr_q[c] <= {PW{1'b0}};
        count_q[c]  <= {CW{1'b0}};
        state_q[c]  <= ST_IDLE;
      end
      protocol_err_q <= 1'b0;
      overflow_err_q <= 1'b0;
      in_vc_ready_q  <= {CHANNELS{1'b1}};
      out_valid_q    <= {CHANNELS{1'b0}};
      out_head_q     <= {CHANNELS{1'b0}};
      out_tail_q     <= {CHANNELS{1'b0}};
      out_flit_q     <= {(CHANNELS*DATA_WIDTH){1'b0}};
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      protocol_err_q <= protocol_err_d;
      overflow_err_q <= overflow_err_d;
      in_vc_ready_q  <= in_vc_ready_d;
      out_valid_q    <= out_valid_d;
      out_head_q     <= out_head_d;
      out_tail_q     <= out_tail_d;
      out_flit_q     <= out_flit_d;
    end
  end

  // Output mapping of registered state.
  always_comb begin
    occupancy = {(CHANNELS*CW){1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      occupancy[c*CW +: CW] = count_q[c];
    end
  end

  assign in_vc_ready  = in_vc_ready_q;
  assign out_valid    = out_valid_q;
  assign out_flit     = out_flit_q;
  assign out_head     = out_head_q;
  assign out_tail     = out_tail_q;
  assign protocol_err = protocol_err_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Self-checking bench for noc_input_vc_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_noc_input_vc_buffer;
  localparam int DW = 128;
  localparam int CH = 2;
  localparam int DEPTH = 4;
  localparam int VC_W = 1;
  localparam int CW = 3;

  logic                 noc_clk = 1'b0;
  logic                 noc_rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [VC_W-1:0]      in_vc = '0;
  logic [DW-1:0]        in_flit = '0;
  logic                 in_head = 1'b0;
  logic                 in_tail = 1'b0;
  logic [CH-1:0]        in_vc_ready;
  logic [CH-1:0]        out_valid;
  logic [CH*DW-1:0]     out_flit;
  logic [CH-1:0]        out_head;
  logic [CH-1:0]        out_tail;
  logic [CH-1:0]        out_ready = '0;
  logic [CH*CW-1:0]     occupancy;
  logic                 protocol_err;
  logic                 overflow_err;

  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] f;
    logic          h;
    logic          t;
  } ent_t;

  ent_t mq[CH][$];
  bit   m_in_pkt[CH];
  bit   m_perr;
  bit   m_oerr;

  noc_input_vc_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .in_valid(in_valid), .in_vc(in_vc),
    .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail), .in_vc_ready(in_vc_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_head(out_head), .out_tail(out_tail),
    .out_ready(out_ready), .occupancy(occupancy), .protocol_err(protocol_err),
    .overflow_err(overflow_err)
  );

  always #5 noc_clk = ~noc_clk;

  // One clock edge: advance the reference model from the applied inputs, then settle.
  task automatic tick();
    bit pop[CH];
    bit push_ok;
    int v;
    ent_t e;
    @(posedge noc_clk);
    if (!noc_rst_n) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        m_in_pkt[c] = 0;
      end
      m_perr = 0;
      m_oerr = 0;
    end else begin
      v = int'(in_vc);
      for (int c = 0; c < CH; c++) pop[c] = (mq[c].size() != 0) && out_ready[c];
      push_ok = in_valid && (v < CH) && (mq[v].size() < DEPTH);
      if (in_valid && !push_ok) m_oerr = 1;
      for (int c = 0; c < CH; c++) if (pop[c]) void'(mq[c].pop_front());
      if (push_ok) begin
        if (in_head) begin
          if (m_in_pkt[v]) m_perr = 1;
          m_in_pkt[v] = !in_tail;
        end else if (!m_in_pkt[v]) begin
          m_perr = 1;
        end else begin
          m_in_pkt[v] = !in_tail;
        end
        e.f = in_flit; e.h = in_head; e.t = in_tail;
        mq[v].push_back(e);
      end
    end
    #1;
  endtask

  task automatic set_in(bit v, int vc, logic [DW-1:0] f, bit h, bit t);
    in_valid = v; in_vc = VC_W'(vc); in_flit = f; in_head = h; in_tail = t;
  endtask

  task automatic do_reset();
    set_in(0, 0, '0, 0, 0);
    noc_rst_n = 1'b0;
    tick();
    noc_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL reset_out_valid: got %b expected 00", out_valid); end
    checks++; if (in_vc_ready !== 2'b11) begin fails++; $display("FAIL reset_in_vc_ready: got %b expected 11", in_vc_ready); end
    checks++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occupancy: got %h expected 0", occupancy); end
    checks++; if (out_flit !== '0 || out_head !== '0 || out_tail !== '0) begin fails++; $display("FAIL reset_out_data: got flit %h head %b tail %b expected 0", out_flit, out_head, out_tail); end
    checks++; if (protocol_err !== 1'b0 || overflow_err !== 1'b0) begin fails++; $display("FAIL reset_errors: got %b%b expected 00", protocol_err, overflow_err); end
  endtask

  task automatic test_packet();
    logic [DW-1:0] exp;
    out_ready = 2'b00;
    set_in(1, 0, DW'('hA1), 1, 0); tick();
    set_in(1, 0, DW'('hA2), 0, 0); tick();
    set_in(1, 0, DW'('hA3), 0, 1); tick();
    set_in(0, 0, '0, 0, 0);
    checks++; if (occupancy[CW-1:0] !== 3'd3) begin fails++; $display("FAIL pkt_occupancy: got %0d expected 3", occupancy[CW-1:0]); end
    checks++; if (out_valid !== 2'b01) begin fails++; $display("FAIL pkt_out_valid: got %b expected 01", out_valid); end
    checks++; if (out_flit[DW-1:0] !== DW'('hA1) || out_head[0] !== 1'b1) begin fails++; $display("FAIL pkt_head_flit: got %h head %b expected a1 head 1", out_flit[DW-1:0], out_head[0]); end
    out_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      exp = DW'('hA1 + k);
      checks++; if (out_valid[0] !== 1'b1 || out_flit[DW-1:0] !== exp) begin fails++; $display("FAIL pkt_pop_%0d: got valid %b flit %h expected valid 1 flit %h", k, out_valid[0], out_flit[DW-1:0], exp); end
      checks++; if (out_tail[0] !== (k == 2)) begin fails++; $display("FAIL pkt_tail_%0d: got %b expected %b", k, out_tail[0], (k == 2)); end
      tick();
    end
    checks++; if (out_valid !== 2'b00 || protocol_err !== 1'b0 || overflow_err !== 1'b0) begin fails++; $display("FAIL pkt_drained: got valid %b errs %b%b expected 00 00", out_valid, protocol_err, overflow_err); end
    out_ready = 2'b00;
  endtask

  task automatic test_overflow();
    out_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin set_in(1, 1, DW'(16 + k), 1, 1); tick(); end
    set_in(0, 0, '0, 0, 0);
    checks++; if (in_vc_ready !== 2'b01) begin fails++; $display("FAIL ovf_ready_full: got %b expected 01", in_vc_ready); end
    set_in(1, 1, DW'(99), 1, 1); tick();
    checks++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow_err); end
    checks++; if (occupancy[CW +: CW] !== 3'd4) begin fails++; $display("FAIL ovf_occ1: got %0d expected 4", occupancy[CW +: CW]); end
    set_in(1, 0, DW'(55), 1, 1); tick();
    checks++; if (occupancy[CW-1:0] !== 3'd1 || out_flit[DW-1:0] !== DW'(55)) begin fails++; $display("FAIL ovf_vc0_writable: got occ %0d flit %h expected 1 37", occupancy[CW-1:0], out_flit[DW-1:0]); end
    out_ready = 2'b10;
    set_in(1, 1, DW'(77), 1, 1); tick();
    checks++; if (occupancy[CW +: CW] !== 3'd3) begin fails++; $display("FAIL full_pop_push_occ: got %0d expected 3", occupancy[CW +: CW]); end
    checks++; if (out_flit[DW +: DW] !== DW'(17)) begin fails++; $display("FAIL full_pop_head: got %h expected 11", out_flit[DW +: DW]); end
    out_ready = 2'b00;
    set_in(1, 1, DW'(78), 1, 1); tick();
    checks++; if (occupancy[CW +: CW] !== 3'd4) begin fails++; $display("FAIL full_next_push: got %0d expected 4", occupancy[CW +: CW]); end
    set_in(0, 0, '0, 0, 0);
    out_ready = 2'b11;
    for (int k = 0; k < 5; k++) tick();
    out_ready = 2'b00;
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL ovf_drain: got %b expected 00", out_valid); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] got[$];
    int occ_max = 0;
    int cyc = 0;
    do_reset();
    out_ready = 2'b01;
    while (got.size() < 10 && cyc < 30) begin
      if (cyc < 10) set_in(1, 0, DW'(cyc), 1, 1);
      else set_in(0, 0, '0, 0, 0);
      if (out_valid[0]) got.push_back(out_flit[DW-1:0]);
      tick();
      if (int'(occupancy[CW-1:0]) > occ_max) occ_max = int'(occupancy[CW-1:0]);
      cyc++;
    end
    set_in(0, 0, '0, 0, 0);
    checks++; if (got.size() != 10) begin fails++; $display("FAIL wrap_count: got %0d expected 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== DW'(k)) begin fails++; $display("FAIL wrap_order_%0d: got %h expected %h", k, got[k], DW'(k)); end
    end
    checks++; if (occ_max > 2) begin fails++; $display("FAIL wrap_occ_max: got %0d expected <=2", occ_max); end
    checks++; if (protocol_err !== 1'b0 || overflow_err !== 1'b0) begin fails++; $display("FAIL wrap_errors: got %b%b expected 00", protocol_err, overflow_err); end
    out_ready = 2'b00;
  endtask

  task automatic test_framing();
    do_reset();
    set_in(1, 0, DW'('h5B), 0, 0); tick();
    set_in(0, 0, '0, 0, 0);
    checks++; if (protocol_err !== 1'b1) begin fails++; $display("FAIL frame_body_idle: got %b expected 1", protocol_err); end
    checks++; if (out_valid[0] !== 1'b1 || out_flit[DW-1:0] !== DW'('h5B)) begin fails++; $display("FAIL frame_body_stored: got valid %b flit %h expected 1 5b", out_valid[0], out_flit[DW-1:0]); end
    do_reset();
    set_in(1, 1, DW'(1), 1, 0); tick();
    checks++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL frame_first_head: got %b expected 0", protocol_err); end
    set_in(1, 1, DW'(2), 1, 0); tick();
    set_in(0, 0, '0, 0, 0);
    checks++; if (protocol_err !== 1'b1 || occupancy[CW +: CW] !== 3'd2) begin fails++; $display("FAIL frame_head_head: got err %b occ %0d expected 1 2", protocol_err, occupancy[CW +: CW]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 2'b00;
    set_in(1, 0, DW'(1), 1, 0); tick();
    set_in(1, 0, DW'(2), 0, 0); tick();
    set_in(1, 1, DW'(3), 1, 0); tick();
    set_in(1, 1, DW'(4), 1, 0); tick();
    do_reset();
    checks++; if (occupancy !== '0 || out_valid !== 2'b00) begin fails++; $display("FAIL midrst_empty: got occ %h valid %b expected 0 00", occupancy, out_valid); end
    checks++; if (in_vc_ready !== 2'b11 || protocol_err !== 1'b0 || overflow_err !== 1'b0) begin fails++; $display("FAIL midrst_state: got ready %b errs %b%b expected 11 00", in_vc_ready, protocol_err, overflow_err); end
    set_in(1, 1, DW'(9), 1, 0); tick();
    set_in(0, 0, '0, 0, 0);
    checks++; if (protocol_err !== 1'b0 || occupancy[CW +: CW] !== 3'd1) begin fails++; $display("FAIL midrst_new_head: got err %b occ %0d expected 0 1", protocol_err, occupancy[CW +: CW]); end
  endtask

  task automatic test_random();
    logic [CH-1:0]    e_valid, e_ready, e_head, e_tail;
    logic [CH*DW-1:0] e_flit;
    logic [CH*CW-1:0] e_occ;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      noc_rst_n = ($urandom_range(0, 149) != 0);
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, CH - 1),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      out_ready = CH'($urandom);
      tick();
      for (int c = 0; c < CH; c++) begin
        e_valid[c] = mq[c].size() != 0;
        e_ready[c] = mq[c].size() != DEPTH;
        e_occ[c*CW +: CW] = CW'(mq[c].size());
        e_flit[c*DW +: DW] = e_valid[c] ? mq[c][0].f : '0;
        e_head[c] = e_valid[c] ? mq[c][0].h : 1'b0;
        e_tail[c] = e_valid[c] ? mq[c][0].t : 1'b0;
      end
      checks++; if (out_valid !== e_valid) begin fails++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", n, out_valid, e_valid); end
      checks++; if (in_vc_ready !== e_ready) begin fails++; $display("FAIL rnd_in_vc_ready@%0d: got %b expected %b", n, in_vc_ready, e_ready); end
      checks++; if (occupancy !== e_occ) begin fails++; $display("FAIL rnd_occupancy@%0d: got %h expected %h", n, occupancy, e_occ); end
      checks++; if (out_flit !== e_flit) begin fails++; $display("FAIL rnd_out_flit@%0d: got %h expected %h", n, out_flit, e_flit); end
      checks++; if (out_head !== e_head || out_tail !== e_tail) begin fails++; $display("FAIL rnd_head_tail@%0d: got %b/%b expected %b/%b", n, out_head, out_tail, e_head, e_tail); end
      checks++; if (protocol_err !== m_perr || overflow_err !== m_oerr) begin fails++; $display("FAIL rnd_errors@%0d: got %b%b expected %b%b", n, protocol_err, overflow_err, m_perr, m_oerr); end
    end
    noc_rst_n = 1'b1;
    set_in(0, 0, '0, 0, 0);
    out_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_overflow();
    test_wrap();
    test_framing();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/noc_input_vc_buffer.md
Name: noc_input_vc_buffer

Overview:
- Per-router input stage that sits directly upstream of the route selector. It takes flits from one link, where each flit is tagged with a virtual-channel index.
- It stores each flit in a per-VC FIFO and presents one flit stream per VC to the route selector's per-channel receiver side.
- It reports per-VC space back to the upstream sender.
- It tracks per-VC packet framing (head/body/tail) and flags protocol and overflow errors.

Parameters:
- DATA_WIDTH, 128, flit width (matches Noc_Data_Width).
- CHANNELS, 2, number of virtual channels (matches Noc_VC_Channel); must be >= 1.
- DEPTH, 4, flit entries per VC FIFO; power of two, >= 2.
- VC_W, $clog2(CHANNELS) (minimum 1), width of the VC index.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream flit valid.
- in_vc  in  VC_W  target VC of the incoming flit.
- in_flit  in  DATA_WIDTH  flit payload.
- in_head  in  1  flit is a packet header.
- in_tail  in  1  flit is a packet tail. A single-flit packet has both in_head and in_tail set.
- in_vc_ready  out  CHANNELS  per-VC space available to upstream.
- out_valid  out  CHANNELS  per-VC FIFO head valid.
- out_flit  out  CHANNELS*DATA_WIDTH  per-VC FIFO head payload; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_head  out  CHANNELS  per-VC header flag of the FIFO head.
- out_tail  out  CHANNELS  per-VC tail flag of the FIFO head.
- out_ready  in  CHANNELS  per-VC downstream accept (route selector ready).
- occupancy  out  CHANNELS*($clog2(DEPTH)+1)  per-VC entry count.
- protocol_err  out  1  sticky framing error.
- overflow_err  out  1  sticky write-while-full or illegal-VC error.

Behaviour:
- Reset (noc_rst_n=0 at a noc_clk edge):
  - All pointers and counts go to 0 and all VC FSMs go to IDLE.
  - protocol_err and overflow_err go to 0.
  - out_valid goes to 0 and in_vc_ready goes to all-ones. out_flit, out_head and out_tail go to 0 (storage is cleared or masked).
  - Reset mid-packet discards all stored flits; no partial state survives.
- Storage: each VC has a DEPTH-entry circular FIFO holding {head, tail, flit}, with write/read pointers of $clog2(DEPTH) bits that wrap naturally from DEPTH-1 to 0.
- in_vc_ready[i] = (count[i] != DEPTH), computed from the registered count only. A same-cycle pop does not free space for a same-cycle push.
- Push: occurs when in_valid && in_vc < CHANNELS && in_vc_ready[in_vc]. The entry is written at the write pointer and count increments at the clock edge.
- Dropped flits (overflow_err <= 1, no state change):
  - in_valid && in_vc >= CHANNELS.
  - in_valid && !in_vc_ready[in_vc].
- Pop: occurs on VC i when out_valid[i] && out_ready[i]. The read pointer advances and count decrements.
- Output drive (first-word fall-through): out_valid[i] = (count[i] != 0). out_flit/out_head/out_tail for VC i show the entry at that VC's read pointer.
- Latency: a flit pushed at edge N is visible on out_valid at edge N (registered storage); it is poppable in the cycle after the push. There is no combinational in->out bypass.
- Simultaneous push and pop on the same VC with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push and pop on different VCs are independent, and multiple VCs may pop in the same cycle.
- Per-VC framing FSM, advanced on accepted pushes only:
  - IDLE + head&tail: stay IDLE (single-flit packet).
  - IDLE + head&!tail: go to BODY.
  - IDLE + !head: protocol_err <= 1; the flit is still stored; stay IDLE.
  - BODY + !head&tail: go to IDLE.
  - BODY + !head&!tail: stay BODY.
  - BODY + head: protocol_err <= 1; the flit is still stored; the FSM then follows the head rule as if it were in IDLE (new packet restarts).
- Error flags stay set until reset. No flit is altered by error detection.
- occupancy[i] = count[i], range 0..DEPTH.

Test Plan:
- Reset, then 3-flit packet on VC0 (head, body, tail; flits 0xA1, 0xA2, 0xA3) with out_ready[0]=0:
  - occupancy[0]=3, out_valid=2'b01, out_flit[0]=0xA1 with out_head[0]=1.
  - Then out_ready[0]=1: pops 0xA1, 0xA2, 0xA3 on three consecutive edges, out_tail[0]=1 on the third; no errors.
- Fill VC1 with DEPTH=4 flits with out_ready=0:
  - in_vc_ready=2'b01.
  - A fifth push to VC1 is dropped and overflow_err=1; occupancy[1] stays 4; VC0 is still writable.
- Full VC1 with out_ready[1]=1 and in_valid to VC1 in the same cycle:
  - The push is rejected (overflow_err=1) and the pop occurs, giving occupancy[1]=3.
  - Next-cycle push accepted, giving occupancy[1]=4.
- Pointer wrap: 10 single-flit packets (head&tail, values 0..9) streamed on VC0 with out_ready[0]=1 continuously:
  - Output order is 0..9, occupancy never exceeds 2, no errors.
- Framing errors:
  - Body flit to VC0 in IDLE sets protocol_err=1, and the flit still appears on out_flit[0].
  - After reset, head then head on VC1 also sets protocol_err=1.
- Reset asserted with 2 flits stored in VC0 and VC1 in BODY:
  - Next edge gives occupancy=0, out_valid=0, in_vc_ready=all-ones, errors 0.
  - A new head&!tail on VC1 is accepted with no protocol_err.
